// File: rtl/output_ram_reader_pkg.sv
// Shared widths and FSM state encoding for the output-RAM drain path.
package output_ram_reader_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned AddrW = 3;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StFlush
    } state_e;

endpackage

// File: rtl/output_ram_reader_rd_fifo2.sv
// Two-entry shift FIFO of {index, last, data}; the head is always entry 0 and reads as zero
// when empty.
module rd_fifo2 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [IDX_W-1:0]  push_idx_i,
    input  logic              push_last_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic              head_valid_o,
    output logic [IDX_W-1:0]  head_idx_o,
    output logic              head_last_o,
    output logic [DATA_W-1:0] head_data_o
);

    localparam int unsigned EntryW = IDX_W + 1 + DATA_W;

    logic [EntryW-1:0] e0_q, e1_q, push_entry;
    logic [1:0]        count_q;

    assign push_entry = {push_idx_i, push_last_i, push_data_i};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) e0_q <= push_entry;
                    else                 e1_q <= push_entry;
                    count_q <= count_q + 2'd1;
                end
                // Shifting in e1_q clears the head to zero once the FIFO empties.
                2'b01: begin
                    e0_q    <= e1_q;
                    e1_q    <= '0;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        e0_q <= e1_q;
                        e1_q <= push_entry;
                    end else begin
                        e0_q <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o                                = count_q;
    assign head_valid_o                           = (count_q != 2'd0);
    assign {head_idx_o, head_last_o, head_data_o} = e0_q;

endmodule

// File: rtl/output_ram_reader.sv
// Drains the output SRAM after a run finishes and streams the words out on valid/ready,
// issuing reads only when the 2-entry FIFO has credit for the returning data.
module output_ram_reader
    import output_ram_reader_pkg::*;
#(
    parameter int unsigned DATA_W    = DataW,
    parameter int unsigned ADDR_W    = AddrW,
    parameter int unsigned WORDS     = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] dut__dom__address,
    output logic              dut__dom__enable,
    output logic              dut__dom__write,
    input  logic [DATA_W-1:0] dom__dut__data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       CntW    = ADDR_W + 1;
    localparam logic [CntW-1:0]   LastCnt = CntW'(WORDS - 1);
    localparam logic [ADDR_W-1:0] Base    = ADDR_W'(BASE_ADDR);

    state_e          state_q;
    logic [CntW-1:0] rd_cnt_q, st_cnt_q;
    logic            inflight_q, done_q;
    logic [1:0]      fifo_count;
    logic [2:0]      credit_used;
    logic            pop, issue;

    assign pop = out_valid & out_ready;

    // A read may issue only if its data is guaranteed a FIFO slot when it returns.
    always_comb begin
        credit_used       = {1'b0, fifo_count} + {2'b00, inflight_q};
        issue             = (state_q == StDrain) && (credit_used < (3'd2 + {2'b00, pop}));
        dut__dom__address = issue ? (Base + rd_cnt_q[ADDR_W-1:0]) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            rd_cnt_q   <= '0;
            st_cnt_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= 1'b0;
            if (issue)      rd_cnt_q <= rd_cnt_q + 1'b1;
            if (inflight_q) st_cnt_q <= st_cnt_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StDrain;
                        rd_cnt_q <= '0;
                        st_cnt_q <= '0;
                    end
                end
                StDrain: begin
                    if (issue && (rd_cnt_q == LastCnt)) state_q <= StFlush;
                end
                StFlush: begin
                    if (pop && out_last) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    rd_fifo2 #(
        .DATA_W (DATA_W),
        .IDX_W  (ADDR_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (inflight_q),
        .push_idx_i   (st_cnt_q[ADDR_W-1:0]),
        .push_last_i  (st_cnt_q == LastCnt),
        .push_data_i  (dom__dut__data),
        .pop_i        (pop),
        .count_o      (fifo_count),
        .head_valid_o (out_valid),
        .head_idx_o   (out_index),
        .head_last_o  (out_last),
        .head_data_o  (out_data)
    );

    assign dut__dom__enable = issue;
    assign dut__dom__write  = 1'b0;
    assign busy             = (state_q != StIdle);
    assign done             = done_q;

endmodule

// File: tb/tb_output_ram_reader.sv
// Directed bench: default reader plus a BASE_ADDR=6/WORDS=4 instance, each with its own SRAM.
module tb_output_ram_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, ready = 1'b0;
    logic        start_b = 1'b0, ready_b = 1'b0;

    logic [2:0]  addr, addr_b, out_index, out_index_b;
    logic        en, en_b, wr, wr_b;
    logic [15:0] rdata, rdata_b, out_data, out_data_b;
    logic        out_valid, out_valid_b, out_last, out_last_b;
    logic        busy, busy_b, done, done_b;
    logic [15:0] mem [8];
    logic [15:0] mem_b [8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (en)   rdata   <= mem[addr];
    always @(posedge clk) if (en_b) rdata_b <= mem_b[addr_b];

    output_ram_reader dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .dut__dom__address (addr),
        .dut__dom__enable  (en),
        .dut__dom__write   (wr),
        .dom__dut__data    (rdata),
        .out_valid         (out_valid),
        .out_ready         (ready),
        .out_data          (out_data),
        .out_index         (out_index),
        .out_last          (out_last),
        .busy              (busy),
        .done              (done)
    );

    output_ram_reader #(
        .WORDS     (4),
        .BASE_ADDR (6)
    ) dut_b (
        .clk               (clk),
        .reset             (reset),
        .start             (start_b),
        .dut__dom__address (addr_b),
        .dut__dom__enable  (en_b),
        .dut__dom__write   (wr_b),
        .dom__dut__data    (rdata_b),
        .out_valid         (out_valid_b),
        .out_ready         (ready_b),
        .out_data          (out_data_b),
        .out_index         (out_index_b),
        .out_last          (out_last_b),
        .busy              (busy_b),
        .done              (done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " addr"},  32'(addr), 32'd0);
        check({tag, " en"},    32'(en), 32'd0);
        check({tag, " wr"},    32'(wr), 32'd0);
        check({tag, " valid"}, 32'(out_valid), 32'd0);
        check({tag, " data"},  32'(out_data), 32'd0);
        check({tag, " index"}, 32'(out_index), 32'd0);
        check({tag, " last"},  32'(out_last), 32'd0);
        check({tag, " busy"},  32'(busy), 32'd0);
        check({tag, " done"},  32'(done), 32'd0);
    endtask

    // Full drain with a repeating ready pattern; optional initial stall and mid-drain start.
    task automatic drain(input logic [3:0] rpat, input int hold0, input int restart_at,
                         input string tag);
        int          got, issued, dones, tail;
        logic        stalled, xfer;
        logic [15:0] held;
        got = 0; issued = 0; dones = 0; tail = 0; stalled = 1'b0; held = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 300 && tail < 4; cyc++) begin
            ready = (cyc <= hold0) ? 1'b0 : rpat[2'(cyc % 4)];
            start = (cyc == restart_at);
            #1;
            xfer = out_valid && ready;
            check({tag, " write"}, 32'(wr), 32'd0);
            if (en) begin
                check({tag, " credit"}, 32'((issued - got - int'(xfer)) < 2), 32'd1);
                issued++;
            end
            if (stalled) check({tag, " stable"}, 32'(out_data), 32'(held));
            if (xfer) begin
                check({tag, " data"},  32'(out_data), 32'h1000 + 32'(got));
                check({tag, " index"}, 32'(out_index), 32'(got % 8));
                check({tag, " last"},  32'(out_last), 32'(got == 7));
                got++;
            end
            stalled = out_valid && !ready;
            held    = out_data;
            if (hold0 > 0 && cyc == hold0) begin
                check({tag, " stall reads"}, 32'(issued), 32'd2);
                check({tag, " stall valid"}, 32'(out_valid), 32'd1);
                check({tag, " stall data"},  32'(out_data), 32'h1000);
            end
            if (done) begin
                dones++;
                check({tag, " busy at done"}, 32'(busy), 32'd0);
            end
            if (dones > 0) tail++;
            tick();
        end
        start = 1'b0;
        check({tag, " words"}, 32'(got), 32'd8);
        check({tag, " dones"}, 32'(dones), 32'd1);
        check({tag, " reads"}, 32'(issued), 32'd8);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]   = 16'h1000 + 16'(i);
            mem_b[i] = 16'h2000 + 16'(i);
        end

        // Reset state
        #1;
        check_idle_outputs("reset");
        tick();
        reset = 1'b1;
        tick();

        // Straight drain with ready held high: exact cycle timing
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c1 en",    32'(en), 32'd1);
        check("c1 addr",  32'(addr), 32'd0);
        check("c1 busy",  32'(busy), 32'd1);
        check("c1 valid", 32'(out_valid), 32'd0);
        tick();
        check("c2 valid", 32'(out_valid), 32'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            check("seq valid", 32'(out_valid), 32'd1);
            check("seq data",  32'(out_data), 32'h1000 + 32'(k));
            check("seq index", 32'(out_index), 32'(k));
            check("seq last",  32'(out_last), 32'(k == 7));
            check("seq done",  32'(done), 32'd0);
            tick();
        end
        check("c11 done",  32'(done), 32'd1);
        check("c11 busy",  32'(busy), 32'd0);
        check("c11 valid", 32'(out_valid), 32'd0);
        tick();
        check("c12 done",  32'(done), 32'd0);
        tick();

        drain(4'b1001, 0, 0, "toggle");
        drain(4'b1111, 20, 0, "stall20");
        drain(4'b1111, 0, 5, "restart");

        // Reset asserted in cycle 6 of a drain
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("c6 busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("postreset");
        drain(4'b1111, 0, 0, "after reset");

        // BASE_ADDR=6, WORDS=4 instance: address wrap
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) begin
                check("b en",   32'(en_b), 32'd1);
                check("b addr", 32'(addr_b), 32'((6 + c - 1) % 8));
            end
            if (c >= 3 && c <= 6) begin
                check("b valid", 32'(out_valid_b), 32'd1);
                check("b data",  32'(out_data_b), 32'h2000 + 32'((6 + c - 3) % 8));
                check("b index", 32'(out_index_b), 32'(c - 3));
                check("b last",  32'(out_last_b), 32'(c == 6));
            end
            if (c == 7) begin
                check("b done",  32'(done_b), 32'd1);
                check("b valid end", 32'(out_valid_b), 32'd0);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
